// File: rtl/imc2x2_seq_inv.sv
// imc2x2_seq_inv -- sequential 2x2 matrix inverter, signed Q(WIDTH-FRAC).FRAC.
//
// Flow: MUL (a*d, b*c) -> SUB (det, |det|, singular test) -> DIV (QW-cycle
// restoring divide giving R = floor(2^(4*FRAC)/|det|)) -> SCALE1 (a_out, d_out)
// -> SCALE2 (b_out, c_out) -> DONE. Two shared multipliers scale the adjugate.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   start                    request, accepted only while busy=0
//   a_in..d_in               matrix [[a,b],[c,d]], sampled on the accept edge
//   busy                     computation in flight
//   done                     one-cycle pulse, results valid
//   singular                 det == 0 for the last accepted matrix
//   ovf                      one or more outputs saturated
//   a_out..d_out             inverse elements, symmetric saturation
module imc2x2_seq_inv #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             busy,
  output logic             done,
  output logic             singular,
  output logic             ovf,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] d_out
);
  localparam int QW = 4*FRAC + 1;      // quotient width
  localparam int DW = 2*WIDTH + 1;     // determinant width
  localparam int PW = WIDTH + QW;      // scale product width
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(QW - 1);
  localparam logic [WIDTH-1:0] MAXP     = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_SUB, S_DIV, S_SCALE1, S_SCALE2, S_DONE
  } state_t;

  state_t state, nxt;

  logic signed [WIDTH-1:0]   a_r, b_r, c_r, d_r;
  logic signed [2*WIDTH-1:0] p1, p2;
  logic                      sgn;
  logic [DW-1:0]             adet, rem;
  logic [QW-1:0]             dvd, quo;
  logic [CW-1:0]             cnt;

  // Returns {saturated, value}. Magnitude truncates toward zero; zero is +0.
  function automatic logic [WIDTH:0] fmt(input logic [PW-1:0] prod, input logic neg);
    logic [PW-1:0]    m;
    logic [WIDTH-1:0] v;
    logic             o;
    m = prod >> (2*FRAC);
    o = m > {{(PW-WIDTH){1'b0}}, MAXP};
    v = o ? MAXP : m[WIDTH-1:0];
    if (neg && v != '0) v = -v;
    return {o, v};
  endfunction

  function automatic logic [WIDTH-1:0] absu(input logic [WIDTH-1:0] x);
    // WIDTH unsigned bits: the most negative value maps to 2^(WIDTH-1) exactly
    return x[WIDTH-1] ? -x : x;
  endfunction

  // determinant and magnitude
  logic signed [DW-1:0] det;
  logic [DW-1:0]        det_mag;
  assign det     = {p1[2*WIDTH-1], p1} - {p2[2*WIDTH-1], p2};
  assign det_mag = det[DW-1] ? -det : det;

  // restoring divider step: bring down the next dividend bit
  logic [DW:0]   trial;
  logic          ge;
  logic [DW-1:0] diff;
  assign trial = {rem, dvd[QW-1]};
  assign ge    = trial >= {1'b0, adet};
  assign diff  = trial[DW-1:0] - adet;

  // shared scale multipliers
  logic [WIDTH-1:0] x0, x1;
  logic             neg0, neg1;
  logic [PW-1:0]    prod0, prod1;
  logic [WIDTH:0]   f0, f1;
  always_comb begin
    if (state == S_SCALE1) begin
      x0   = d_r;                       // -> a_out
      x1   = a_r;                       // -> d_out
      neg0 = d_r[WIDTH-1] ^ sgn;
      neg1 = a_r[WIDTH-1] ^ sgn;
    end else begin
      x0   = b_r;                       // -> b_out (negated)
      x1   = c_r;                       // -> c_out (negated)
      neg0 = ~b_r[WIDTH-1] ^ sgn;
      neg1 = ~c_r[WIDTH-1] ^ sgn;
    end
  end
  assign prod0 = {{QW{1'b0}}, absu(x0)} * {{WIDTH{1'b0}}, quo};
  assign prod1 = {{QW{1'b0}}, absu(x1)} * {{WIDTH{1'b0}}, quo};
  assign f0    = fmt(prod0, neg0);
  assign f1    = fmt(prod1, neg1);

  // FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b1;
    done = 1'b0;
    case (state)
      S_IDLE:   begin busy = 1'b0; if (start) nxt = S_MUL; end
      S_DONE:   begin busy = 1'b0; done = 1'b1; nxt = start ? S_MUL : S_IDLE; end
      S_MUL:    nxt = S_SUB;
      S_SUB:    nxt = (det_mag == '0) ? S_DONE : S_DIV;
      S_DIV:    if (cnt == CNT_LAST) nxt = S_SCALE1;
      S_SCALE1: nxt = S_SCALE2;
      S_SCALE2: nxt = S_DONE;
      default:  begin busy = 1'b0; nxt = S_IDLE; end
    endcase
  end

  // datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r <= '0; b_r <= '0; c_r <= '0; d_r <= '0;
      p1 <= '0; p2 <= '0; sgn <= 1'b0; adet <= '0;
      rem <= '0; dvd <= '0; quo <= '0; cnt <= '0;
      singular <= 1'b0; ovf <= 1'b0;
      a_out <= '0; b_out <= '0; c_out <= '0; d_out <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_r <= a_in; b_r <= b_in; c_r <= c_in; d_r <= d_in;
            ovf <= 1'b0;
          end
        end
        S_MUL: begin
          p1 <= a_r * d_r;
          p2 <= b_r * c_r;
        end
        S_SUB: begin
          sgn  <= det[DW-1];
          adet <= det_mag;
          rem  <= '0;
          dvd  <= {1'b1, {(QW-1){1'b0}}};  // 2^(4*FRAC)
          quo  <= '0;
          cnt  <= '0;
          if (det_mag == '0) begin
            singular <= 1'b1;
            ovf      <= 1'b0;
            a_out <= '0; b_out <= '0; c_out <= '0; d_out <= '0;
          end else begin
            singular <= 1'b0;
          end
        end
        S_DIV: begin
          rem <= ge ? diff : trial[DW-1:0];
          quo <= {quo[QW-2:0], ge};
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
        end
        S_SCALE1: begin
          a_out <= f0[WIDTH-1:0];
          d_out <= f1[WIDTH-1:0];
          ovf   <= ovf | f0[WIDTH] | f1[WIDTH];
        end
        S_SCALE2: begin
          b_out <= f0[WIDTH-1:0];
          c_out <= f1[WIDTH-1:0];
          ovf   <= ovf | f0[WIDTH] | f1[WIDTH];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imc2x2_seq_inv.sv
// Directed bench for imc2x2_seq_inv at default parameters (WIDTH=16, FRAC=8).
module tb_imc2x2_seq_inv;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] a_in, b_in, c_in, d_in;
  logic        busy, done, singular, ovf;
  logic [15:0] a_out, b_out, c_out, d_out;

  int errors = 0;
  int checks = 0;
  int lat, lat2, npulse;

  always #5 clk = ~clk;

  imc2x2_seq_inv #(.WIDTH(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .busy(busy), .done(done), .singular(singular), .ovf(ovf),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one matrix, then wait (bounded) for done. If poke>0, a stray start
  // with different inputs is driven for one cycle, poke cycles after accept.
  task automatic run(input logic [15:0] a, b, c, d, input int poke, output int n);
    @(negedge clk);
    a_in = a; b_in = b; c_in = c; d_in = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (poke > 0 && n == poke) begin
        start = 1'b1; a_in = 16'h1234; b_in = 16'h0777; c_in = 16'hF00F; d_in = 16'h0003;
      end else if (poke > 0 && n == poke + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic outs(input string t, input logic [15:0] ea, eb, ec, ed,
                      input logic es, input logic eo);
    chk({t, ".a_out"}, 32'(a_out), 32'(ea));
    chk({t, ".b_out"}, 32'(b_out), 32'(eb));
    chk({t, ".c_out"}, 32'(c_out), 32'(ec));
    chk({t, ".d_out"}, 32'(d_out), 32'(ed));
    chk({t, ".singular"}, 32'(singular), 32'(es));
    chk({t, ".ovf"}, 32'(ovf), 32'(eo));
  endtask

  // done must be a single-cycle pulse
  task automatic after_done(input string t);
    @(posedge clk); #1;
    chk({t, ".done_pulse"}, 32'(done), 32'd0);
    chk({t, ".busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    outs("rst", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // identity
    run(16'h0100, 16'h0000, 16'h0000, 16'h0100, 0, lat);
    chk("ident.latency", 32'(lat), 32'd37);
    outs("ident", 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1'b0);
    after_done("ident");

    // [[1,2],[3,4]]: det=-131072, R=32768
    run(16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, lat);
    chk("m1234.latency", 32'(lat), 32'd37);
    outs("m1234", 16'hFE00, 16'h0100, 16'h0180, 16'hFF80, 1'b0, 1'b0);

    // diagonal [[2,0],[0,4]]
    run(16'h0200, 16'h0000, 16'h0000, 16'h0400, 0, lat);
    outs("diag", 16'h0080, 16'h0000, 16'h0000, 16'h0040, 1'b0, 1'b0);

    // singular [[1,2],[2,4]]
    run(16'h0100, 16'h0200, 16'h0200, 16'h0400, 0, lat);
    chk("sing.latency", 32'(lat), 32'd2);
    outs("sing", 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    after_done("sing");
    run(16'h0100, 16'h0000, 16'h0000, 16'h0100, 0, lat);
    outs("unsing", 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1'b0);

    // overflow: det=1, R=2^32
    run(16'h0001, 16'h0000, 16'h0000, 16'h0001, 0, lat);
    outs("ovf_pos", 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1);
    run(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 0, lat);
    outs("ovf_neg", 16'h8001, 16'h0000, 16'h0000, 16'h8001, 1'b0, 1'b1);
    // ovf clears on the next non-saturating operation
    run(16'h0100, 16'h0000, 16'h0000, 16'h0100, 0, lat);
    chk("ovf_clear", 32'(ovf), 32'd0);

    // stray start during DIV is ignored
    run(16'h0100, 16'h0200, 16'h0300, 16'h0400, 10, lat);
    chk("poke.latency", 32'(lat), 32'd37);
    outs("poke", 16'hFE00, 16'h0100, 16'h0180, 16'hFF80, 1'b0, 1'b0);
    after_done("poke");

    // reset mid-DIV aborts with no done
    @(negedge clk);
    a_in = 16'h0200; b_in = 16'h0000; c_in = 16'h0000; d_in = 16'h0400; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    chk("abort.busy", 32'(busy), 32'd0);
    outs("abort", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    npulse = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done === 1'b1) npulse++;
    end
    chk("abort.no_done", 32'(npulse), 32'd0);

    // start held high: back-to-back accept in the DONE cycle
    @(negedge clk);
    a_in = 16'h0100; b_in = 16'h0000; c_in = 16'h0000; d_in = 16'h0100; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("b2b.first_latency", 32'(lat), 32'd37);
    outs("b2b1", 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1'b0);
    a_in = 16'h0100; b_in = 16'h0200; c_in = 16'h0300; d_in = 16'h0400;
    lat2 = 0;
    do begin
      @(posedge clk); #1; lat2++;
    end while (done !== 1'b1 && lat2 < 100);
    start = 1'b0;
    chk("b2b.spacing", 32'(lat2), 32'd38);
    outs("b2b2", 16'hFE00, 16'h0100, 16'h0180, 16'hFF80, 1'b0, 1'b0);
    after_done("b2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
